kernel_prueba_example_burst_framer: RTL



---
 rtl/kernel_prueba_example_burst_framer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/kernel_prueba_example_burst_framer.sv
// Frames a fixed-length AXI4-Stream transfer into AXI4 write bursts: issues one length request per
// burst and regenerates tlast on the final beat of each burst.
module kernel_prueba_example_burst_framer #(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_MAX_BURST_BEATS  = 64
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_beats,
    output logic                            ctrl_busy,
    output logic                            ctrl_done,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            burst_req_valid,
    input  logic                            burst_req_ready,
    output logic [7:0]                      burst_req_len
);

    localparam int unsigned DW   = C_AXIS_TDATA_WIDTH;
    localparam int unsigned KW   = C_AXIS_TDATA_WIDTH / 8;
    localparam int unsigned CntW = C_XFER_SIZE_WIDTH;

    localparam logic [CntW-1:0] MaxBeats = CntW'(C_MAX_BURST_BEATS);
    localparam logic [7:0]      MaxLen   = 8'(C_MAX_BURST_BEATS - 1);
    localparam logic [8:0]      LastIdx  = 9'(C_MAX_BURST_BEATS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] req_rem_q, req_rem_d;
    logic [CntW-1:0] data_rem_q, data_rem_d;
    logic [CntW-1:0] acc_rem_q, acc_rem_d;
    logic            req_valid_q, req_valid_d;
    logic [7:0]      req_len_q, req_len_d;
    logic [8:0]      beat_cnt_q, beat_cnt_d;

    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [KW-1:0]   out_keep_q, out_keep_d;
    logic            skid_valid_q, skid_valid_d;
    logic            skid_last_q, skid_last_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic [KW-1:0]   skid_keep_q, skid_keep_d;

    logic s_hs, m_hs, in_last;
    logic unused_tlast;

    assign unused_tlast = s_axis_tlast;

    assign s_axis_tready   = (state_q == StRun) && !skid_valid_q && (acc_rem_q != '0);
    assign s_hs            = s_axis_tvalid && s_axis_tready;
    assign m_hs            = out_valid_q && m_axis_tready;
    // Every burst but the final one is full-size, so the tail is marked by the transfer end.
    assign in_last         = (beat_cnt_q == LastIdx) || (acc_rem_q == CntW'(1));

    assign ctrl_busy       = (state_q == StRun);
    assign ctrl_done       = (state_q == StDone);
    assign m_axis_tvalid   = out_valid_q;
    assign m_axis_tdata    = out_data_q;
    assign m_axis_tkeep    = out_keep_q;
    assign m_axis_tlast    = out_last_q;
    assign burst_req_valid = req_valid_q;
    assign burst_req_len   = req_len_q;

    always_comb begin
        state_d      = state_q;
        req_rem_d    = req_rem_q;
        data_rem_d   = data_rem_q;
        acc_rem_d    = acc_rem_q;
        req_valid_d  = req_valid_q;
        req_len_d    = req_len_q;
        beat_cnt_d   = beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;

        unique case (state_q)
            StIdle: begin
                if (ctrl_start) begin
                    if (ctrl_xfer_beats == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StRun;
                        req_rem_d  = ctrl_xfer_beats;
                        data_rem_d = ctrl_xfer_beats;
                        acc_rem_d  = ctrl_xfer_beats;
                        beat_cnt_d = '0;
                    end
                end
            end
            StRun: begin
                // Request is dropped for a cycle after each handshake before the next is posted.
                if (req_valid_q) begin
                    if (burst_req_ready) begin
                        req_valid_d = 1'b0;
                        req_rem_d   = req_rem_q - (CntW'(req_len_q) + CntW'(1));
                    end
                end else if (req_rem_q != '0) begin
                    req_valid_d = 1'b1;
                    req_len_d   = (req_rem_q >= MaxBeats) ? MaxLen : 8'(req_rem_q - CntW'(1));
                end
                if (s_hs) begin
                    acc_rem_d  = acc_rem_q - CntW'(1);
                    beat_cnt_d = in_last ? '0 : beat_cnt_q + 9'd1;
                end
                if (m_hs) begin
                    data_rem_d = data_rem_q - CntW'(1);
                end
                if ((req_rem_q == '0) && (data_rem_q == '0) && !out_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (!out_valid_q || m_axis_tready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                skid_valid_d = 1'b0;
            end else if (s_hs) begin
                out_valid_d = 1'b1;
                out_last_d  = in_last;
                out_data_d  = s_axis_tdata;
                out_keep_d  = s_axis_tkeep;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end else if (s_hs) begin
            skid_valid_d = 1'b1;
            skid_last_d  = in_last;
            skid_data_d  = s_axis_tdata;
            skid_keep_d  = s_axis_tkeep;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StIdle;
            req_rem_q    <= '0;
            data_rem_q   <= '0;
            acc_rem_q    <= '0;
            req_valid_q  <= 1'b0;
            req_len_q    <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_rem_q    <= req_rem_d;
            data_rem_q   <= data_rem_d;
            acc_rem_q    <= acc_rem_d;
            req_valid_q  <= req_valid_d;
            req_len_q    <= req_len_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
        end
    end

    // Payload registers are qualified by their valid flags and need no reset.
    always_ff @(posedge aclk) begin
        out_data_q  <= out_data_d;
        out_keep_q  <= out_keep_d;
        skid_data_q <= skid_data_d;
        skid_keep_q <= skid_keep_d;
    end

endmodule
